exme_skid_buffer: RTL and testbench

// - Parametrised EX->ME pipeline buffer for the FPU pipeline; next-generation EX/ME stage register.
// - Adds a valid/ready handshake, a 2-entry skid (ME can stall without EX losing a result),
//   a synchronous flush, and a forwarding lookup port for EX-stage hazard bypass.
// - Sits between the FPU execute stage (producer) and the memory stage (consumer).

---
 rtl/exme_skid_buffer_if.sv | 41 ++++
 rtl/exme_skid_buffer.sv | 174 +++++++++++++++++
 tb/tb_exme_skid_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/exme_skid_buffer_if.sv
// EX->ME handshake bundle: producer side (in_*), consumer side (out_*),
// occupancy status and the forwarding lookup port.
interface exme_skid_buffer_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int FLAGW = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] in_result;
    logic [ASIZE-1:0] in_rd_addr;
    logic             in_wr_en;
    logic [FLAGW-1:0] in_flags;

    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_result;
    logic [ASIZE-1:0] out_rd_addr;
    logic             out_wr_en;
    logic [FLAGW-1:0] out_flags;

    logic [1:0]       occupancy;

    logic [ASIZE-1:0] fwd_addr;
    logic             fwd_hit;
    logic [DSIZE-1:0] fwd_data;

    modport slave (
        input  in_valid, in_result, in_rd_addr, in_wr_en, in_flags,
        input  out_ready, fwd_addr,
        output in_ready, out_valid, out_result, out_rd_addr, out_wr_en, out_flags,
        output occupancy, fwd_hit, fwd_data
    );

    modport master (
        output in_valid, in_result, in_rd_addr, in_wr_en, in_flags,
        output out_ready, fwd_addr,
        input  in_ready, out_valid, out_result, out_rd_addr, out_wr_en, out_flags,
        input  occupancy, fwd_hit, fwd_data
    );
endinterface

// File: rtl/exme_skid_buffer.sv
// EX->ME pipeline register with a 2-entry skid (head + skid), synchronous flush
// and a combinational forwarding lookup over the held entries.
module exme_skid_buffer #(
    parameter int DSIZE    = 32,
    parameter int ASIZE    = 5,
    parameter int FLAGW    = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    exme_skid_buffer_if.slave    bus
);
    // State codes double as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]       state_r;
    logic [1:0]       state_n_s;
    logic             out_valid_r;
    logic             out_wr_en_r;
    logic             in_ready_r;

    logic [DSIZE-1:0] head_result_r;
    logic [ASIZE-1:0] head_rd_r;
    logic             head_wr_r;
    logic [FLAGW-1:0] head_flags_r;

    logic [DSIZE-1:0] skid_result_r;
    logic [ASIZE-1:0] skid_rd_r;
    logic             skid_wr_r;
    logic [FLAGW-1:0] skid_flags_r;

    logic             accept_s;
    logic             retire_s;
    logic             head_load_s;
    logic             head_shift_s;
    logic             skid_load_s;
    logic             head_wr_n_s;

    logic             zero_addr_s;
    logic             skid_hit_s;
    logic             head_hit_s;
    logic [DSIZE-1:0] fwd_data_s;

    assign accept_s = bus.in_valid & in_ready_r;
    assign retire_s = out_valid_r & bus.out_ready;

    // Next-state and datapath steering; flush overrides any accept/retire.
    always_comb begin
        state_n_s    = state_r;
        head_load_s  = 1'b0;
        head_shift_s = 1'b0;
        skid_load_s  = 1'b0;
        if (flush) begin
            state_n_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_load_s = 1'b1;
                        state_n_s   = ST_ONE;
                    end else begin
                        state_n_s   = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && retire_s) begin
                        head_load_s = 1'b1;
                        state_n_s   = ST_ONE;
                    end else if (accept_s) begin
                        skid_load_s = 1'b1;
                        state_n_s   = ST_FULL;
                    end else if (retire_s) begin
                        state_n_s   = ST_EMPTY;
                    end else begin
                        state_n_s   = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (retire_s) begin
                        head_shift_s = 1'b1;
                        state_n_s    = ST_ONE;
                    end else begin
                        state_n_s    = ST_FULL;
                    end
                end
                default: begin
                    state_n_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Write enable the head will hold after this edge, so out_wr_en can be registered.
    always_comb begin
        head_wr_n_s = head_wr_r;
        if (head_load_s) begin
            head_wr_n_s = bus.in_wr_en;
        end else if (head_shift_s) begin
            head_wr_n_s = skid_wr_r;
        end else begin
            head_wr_n_s = head_wr_r;
        end
    end

    // State, status flags and both storage entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_EMPTY;
            out_valid_r   <= 1'b0;
            out_wr_en_r   <= 1'b0;
            in_ready_r    <= 1'b1;
            head_result_r <= {DSIZE{1'b0}};
            head_rd_r     <= {ASIZE{1'b0}};
            head_wr_r     <= 1'b0;
            head_flags_r  <= {FLAGW{1'b0}};
            skid_result_r <= {DSIZE{1'b0}};
            skid_rd_r     <= {ASIZE{1'b0}};
            skid_wr_r     <= 1'b0;
            skid_flags_r  <= {FLAGW{1'b0}};
        end else begin
            state_r     <= state_n_s;
            out_valid_r <= (state_n_s != ST_EMPTY);
            out_wr_en_r <= head_wr_n_s & (state_n_s != ST_EMPTY);
            in_ready_r  <= (state_n_s != ST_FULL);
            head_wr_r   <= head_wr_n_s;
            if (head_load_s) begin
                head_result_r <= bus.in_result;
                head_rd_r     <= bus.in_rd_addr;
                head_flags_r  <= bus.in_flags;
            end else if (head_shift_s) begin
                head_result_r <= skid_result_r;
                head_rd_r     <= skid_rd_r;
                head_flags_r  <= skid_flags_r;
            end
            if (skid_load_s) begin
                skid_result_r <= bus.in_result;
                skid_rd_r     <= bus.in_rd_addr;
                skid_wr_r     <= bus.in_wr_en;
                skid_flags_r  <= bus.in_flags;
            end
        end
    end

    assign zero_addr_s = ZERO_REG && (bus.fwd_addr == {ASIZE{1'b0}});
    assign skid_hit_s  = (state_r == ST_FULL) && skid_wr_r &&
                         (skid_rd_r == bus.fwd_addr) && !zero_addr_s;
    assign head_hit_s  = out_valid_r && head_wr_r &&
                         (head_rd_r == bus.fwd_addr) && !zero_addr_s;

    // Skid holds the younger entry, so it wins when both match.
    always_comb begin
        fwd_data_s = {DSIZE{1'b0}};
        if (skid_hit_s) begin
            fwd_data_s = skid_result_r;
        end else if (head_hit_s) begin
            fwd_data_s = head_result_r;
        end else begin
            fwd_data_s = {DSIZE{1'b0}};
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = head_result_r;
    assign bus.out_rd_addr = head_rd_r;
    assign bus.out_wr_en   = out_wr_en_r;
    assign bus.out_flags   = head_flags_r;
    assign bus.occupancy   = state_r;
    assign bus.fwd_hit     = skid_hit_s | head_hit_s;
    assign bus.fwd_data    = fwd_data_s;
endmodule

// File: tb/tb_exme_skid_buffer.sv
// Directed bench for exme_skid_buffer: occupancy model plus an in-order scoreboard
// of accepted entries compared as they retire toward ME.
module tb_exme_skid_buffer;
    localparam int DSIZE = 32;
    localparam int ASIZE = 5;
    localparam int FLAGW = 5;

    typedef struct packed {
        logic [DSIZE-1:0] res;
        logic [ASIZE-1:0] rd;
        logic             wr;
        logic [FLAGW-1:0] fl;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    exme_skid_buffer_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FLAGW(FLAGW)) bus ();

    exme_skid_buffer #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FLAGW(FLAGW), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_occ = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [DSIZE-1:0] res, input logic [ASIZE-1:0] rd,
                       input logic wr, input logic [FLAGW-1:0] fl);
        bus.in_valid   = v;
        bus.in_result  = res;
        bus.in_rd_addr = rd;
        bus.in_wr_en   = wr;
        bus.in_flags   = fl;
    endtask

    // One clock: retire/accept decided from the bench model, then post-edge status checks.
    task automatic tick();
        bit   ret;
        bit   acc;
        bit   clr;
        ent_t e;
        clr = (rst === 1'b1) || (flush === 1'b1);
        ret = !clr && (model_occ > 0) && (bus.out_ready === 1'b1);
        acc = !clr && (model_occ < 2) && (bus.in_valid === 1'b1);
        if (ret) begin
            chk("sb_depth", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_valid", bus.out_valid, 1'b1);
                chk("out_result", bus.out_result, e.res);
                chk("out_rd_addr", bus.out_rd_addr, e.rd);
                chk("out_wr_en", bus.out_wr_en, e.wr);
                chk("out_flags", bus.out_flags, e.fl);
            end
        end
        if (acc) begin
            sb.push_back({bus.in_result, bus.in_rd_addr, bus.in_wr_en, bus.in_flags});
        end
        @(posedge clk);
        #1;
        if (clr) begin
            model_occ = 0;
            sb.delete();
        end else begin
            model_occ = model_occ + int'(acc) - int'(ret);
        end
        chk("occupancy", bus.occupancy, 64'(model_occ));
        chk("out_valid_st", bus.out_valid, 64'(model_occ > 0));
        chk("in_ready", bus.in_ready, 64'(model_occ != 2));
        if (model_occ == 0) chk("out_wr_en_idle", bus.out_wr_en, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.fwd_addr = 5'd0;
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);

        // Reset
        tick();
        tick();
        chk("rst_result", bus.out_result, 32'h0);
        chk("rst_rd", bus.out_rd_addr, 5'd0);
        chk("rst_flags", bus.out_flags, 5'd0);
        rst = 1'b0;

        // Pass-through with one-cycle latency
        bus.out_ready = 1'b1;
        put(1'b1, 32'hAFAB0000, 5'd30, 1'b1, 5'd0);
        tick();
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        chk("pt_result", bus.out_result, 32'hAFAB0000);
        chk("pt_rd", bus.out_rd_addr, 5'd30);
        tick();

        // Stall then drain through the skid
        bus.out_ready = 1'b0;
        put(1'b1, 32'h1, 5'd1, 1'b1, 5'd1);
        tick();
        put(1'b1, 32'h2, 5'd2, 1'b0, 5'd2);
        tick();
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        chk("stall_result", bus.out_result, 32'h1);
        chk("stall_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk("skid_result", bus.out_result, 32'h2);
        tick();

        // Streaming 8 back-to-back entries
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 32'h10 + 32'(i), 5'(i), 1'b1, 5'(i));
            tick();
        end
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        tick();

        // Flush a full buffer while an accept is attempted
        bus.out_ready = 1'b0;
        put(1'b1, 32'hA1, 5'd4, 1'b1, 5'd0);
        tick();
        put(1'b1, 32'hA2, 5'd5, 1'b1, 5'd0);
        tick();
        put(1'b1, 32'hDEAD, 5'd3, 1'b1, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        chk("flush_occ", bus.occupancy, 2'd0);
        bus.out_ready = 1'b1;
        tick();
        tick();

        // Forwarding: skid beats head on the same address
        bus.out_ready = 1'b0;
        put(1'b1, 32'hAA, 5'd7, 1'b1, 5'd0);
        tick();
        put(1'b1, 32'hBB, 5'd7, 1'b1, 5'd0);
        tick();
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        bus.fwd_addr = 5'd7;
        #1;
        chk("fwd_young_hit", bus.fwd_hit, 1'b1);
        chk("fwd_young_data", bus.fwd_data, 32'hBB);
        bus.fwd_addr = 5'd3;
        #1;
        chk("fwd_miss_hit", bus.fwd_hit, 1'b0);
        chk("fwd_miss_data", bus.fwd_data, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Head-only hit and hardwired zero register
        put(1'b1, 32'hCC, 5'd5, 1'b1, 5'd0);
        tick();
        put(1'b1, 32'h55, 5'd0, 1'b1, 5'd0);
        tick();
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        bus.fwd_addr = 5'd5;
        #1;
        chk("fwd_head_hit", bus.fwd_hit, 1'b1);
        chk("fwd_head_data", bus.fwd_data, 32'hCC);
        bus.fwd_addr = 5'd0;
        #1;
        chk("fwd_zero_hit", bus.fwd_hit, 1'b0);
        chk("fwd_zero_data", bus.fwd_data, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Entry without write enable never forwards
        put(1'b1, 32'h77, 5'd9, 1'b0, 5'd3);
        tick();
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        bus.fwd_addr = 5'd9;
        #1;
        chk("fwd_nowr_hit", bus.fwd_hit, 1'b0);
        bus.out_ready = 1'b1;
        tick();

        // Reset while stalled with two entries
        bus.out_ready = 1'b0;
        put(1'b1, 32'hE1, 5'd11, 1'b1, 5'd1);
        tick();
        put(1'b1, 32'hE2, 5'd12, 1'b1, 5'd2);
        tick();
        put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_result", bus.out_result, 32'h0);
        chk("midrst_rd", bus.out_rd_addr, 5'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
